// File: rtl/cam_capture_pkg.sv
// Shared image parameters for the camera capture and processing stages.
// Holds frame geometry, decimation factor, buffer widths and FSM encodings.
package cam_capture_pkg;

  localparam int unsigned cam_in_cols  = 640;
  localparam int unsigned cam_in_rows  = 480;
  localparam int unsigned img_cols     = 80;
  localparam int unsigned img_rows     = 60;
  localparam int unsigned img_dec      = 8;
  localparam int unsigned img_dec_bits = $clog2(img_dec);
  localparam int unsigned nb_img_pxls  = 13;
  localparam int unsigned nb_buf       = 12;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_VSYNC  = 2'd1;
  localparam state_t S_ACTIVE = 2'd2;

endpackage

// File: rtl/cam_capture_if.sv
// Camera byte stream plus frame-buffer write port of the capture stage.
// master drives the camera side and reads writes back; slave is the capture block.
interface cam_capture_if;
  import cam_capture_pkg::*;

  logic                   cap_en;
  logic                   cam_pclk;
  logic                   cam_vsync;
  logic                   cam_href;
  logic [7:0]             cam_data;
  logic                   cap_we;
  logic [nb_img_pxls-1:0] cap_addr;
  logic [nb_buf-1:0]      cap_pxl;
  logic                   frame_done;

  modport master (
    output cap_en, cam_pclk, cam_vsync, cam_href, cam_data,
    input  cap_we, cap_addr, cap_pxl, frame_done
  );

  modport slave (
    input  cap_en, cam_pclk, cam_vsync, cam_href, cam_data,
    output cap_we, cap_addr, cap_pxl, frame_done
  );

endinterface

// File: rtl/cam_sync.sv
// Two-flop synchroniser for the camera pins plus pclk/vsync/href edge detection.
// Data travels with pclk so it is aligned to the detected pclk rise.
module cam_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       pclk_i,
  input  logic       vsync_i,
  input  logic       href_i,
  input  logic [7:0] data_i,
  output logic       pclk_rise_o,
  output logic       vsync_o,
  output logic       vsync_rise_o,
  output logic       vsync_fall_o,
  output logic       href_o,
  output logic       href_fall_o,
  output logic [7:0] data_o
);

  logic [10:0] meta_q;
  logic [10:0] sync_q;
  logic [2:0]  prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= {pclk_i, vsync_i, href_i, data_i};
      sync_q <= meta_q;
      prev_q <= sync_q[10:8];
    end
  end

  assign vsync_o      = sync_q[9];
  assign href_o       = sync_q[8];
  assign data_o       = sync_q[7:0];
  assign pclk_rise_o  =  sync_q[10] & ~prev_q[2];
  assign vsync_rise_o =  sync_q[9]  & ~prev_q[1];
  assign vsync_fall_o = ~sync_q[9]  &  prev_q[1];
  assign href_fall_o  = ~sync_q[8]  &  prev_q[0];

endmodule

// File: rtl/cam_capture.sv
// Captures an RGB565 camera frame, decimates 8x8 and writes RGB444 pixels
// to a frame buffer at sequential addresses.
module cam_capture
  import cam_capture_pkg::*;
#(
  parameter int unsigned c_in_cols     = cam_in_cols,
  parameter int unsigned c_in_rows     = cam_in_rows,
  parameter int unsigned c_img_cols    = img_cols,
  parameter int unsigned c_img_rows    = img_rows,
  parameter int unsigned c_nb_img_pxls = nb_img_pxls,
  parameter int unsigned c_nb_buf      = nb_buf
) (
  input logic          clk,
  input logic          rst,
  cam_capture_if.slave bus
);

  localparam int unsigned ColW  = $clog2(c_in_cols);
  localparam int unsigned LineW = $clog2(c_in_rows);
  localparam logic [ColW-1:0]          ColMax  = ColW'(c_in_cols - 1);
  localparam logic [LineW-1:0]         LineMax = LineW'(c_in_rows - 1);
  localparam logic [c_nb_img_pxls-1:0] AddrMax = c_nb_img_pxls'(c_img_cols * c_img_rows - 1);

  logic       pclk_rise, vsync_s, vsync_rise, vsync_fall, href_s, href_fall;
  logic [7:0] data_s;

  cam_sync u_sync (
    .clk          (clk),
    .rst          (rst),
    .pclk_i       (bus.cam_pclk),
    .vsync_i      (bus.cam_vsync),
    .href_i       (bus.cam_href),
    .data_i       (bus.cam_data),
    .pclk_rise_o  (pclk_rise),
    .vsync_o      (vsync_s),
    .vsync_rise_o (vsync_rise),
    .vsync_fall_o (vsync_fall),
    .href_o       (href_s),
    .href_fall_o  (href_fall),
    .data_o       (data_s)
  );

  state_t                   state_q, state_d;
  logic [ColW-1:0]          col_q;
  logic [LineW-1:0]         line_q;
  logic                     tog_q;
  logic [6:0]               byte1_q;
  logic [c_nb_img_pxls-1:0] addr_q;
  logic                     we_q;
  logic [c_nb_buf-1:0]      pxl_q;
  logic                     done_q;
  logic                     active, enter, byte_en, store;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.cap_en && vsync_s) state_d = S_VSYNC;
      S_VSYNC:  if (vsync_fall) state_d = S_ACTIVE;
      S_ACTIVE: if (vsync_rise) state_d = bus.cap_en ? S_VSYNC : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign active  = (state_q == S_ACTIVE);
  assign enter   = (state_q == S_VSYNC) && vsync_fall;
  assign byte_en = active && pclk_rise && href_s;
  // Second byte of a pixel on a column and line that survive 8x8 decimation.
  assign store   = byte_en && tog_q && (col_q[img_dec_bits-1:0] == '0) &&
                   (line_q[img_dec_bits-1:0] == '0) && (addr_q <= AddrMax);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      line_q  <= '0;
      tog_q   <= 1'b0;
      byte1_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      pxl_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= store;
      done_q  <= active && vsync_rise;
      if (store) pxl_q <= {byte1_q, data_s[7], data_s[4:1]};
      if (enter) begin
        col_q  <= '0;
        line_q <= '0;
        tog_q  <= 1'b0;
        addr_q <= '0;
      end else begin
        // Address advances in the write cycle so cap_addr matches cap_we.
        if (we_q) addr_q <= addr_q + 1'b1;
        if (active && href_fall) begin
          col_q <= '0;
          tog_q <= 1'b0;
          if (line_q != LineMax) line_q <= line_q + 1'b1;
        end else if (byte_en) begin
          tog_q <= ~tog_q;
          if (!tog_q) byte1_q <= {data_s[7:4], data_s[2:0]};
          else if (col_q != ColMax) col_q <= col_q + 1'b1;
        end
      end
    end
  end

  assign bus.cap_we     = we_q;
  assign bus.cap_addr   = addr_q;
  assign bus.cap_pxl    = pxl_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_cam_capture.sv
// Self-checking bench for cam_capture, run on a scaled-down 32x24 camera / 4x3 image
// so whole frames fit a short simulation; expectations come from a pixel-level model.
module tb_cam_capture;
  import cam_capture_pkg::*;

  localparam int InCols  = 32;
  localparam int InRows  = 24;
  localparam int ImgCols = 4;
  localparam int ImgRows = 3;
  localparam int ImgPix  = ImgCols * ImgRows;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cam_capture_if bus ();

  cam_capture #(
    .c_in_cols     (InCols),
    .c_in_rows     (InRows),
    .c_img_cols    (ImgCols),
    .c_img_rows    (ImgRows),
    .c_nb_img_pxls (nb_img_pxls),
    .c_nb_buf      (nb_buf)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   failures = 0;
  int   got_addr[$], got_pxl[$], exp_addr[$], exp_pxl[$];
  int   done_cnt = 0;
  int   we_long = 0;
  logic we_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.cap_we === 1'b1) begin
      got_addr.push_back(int'(bus.cap_addr));
      got_pxl.push_back(int'(bus.cap_pxl));
      if (we_prev) we_long++;
    end
    if (bus.frame_done === 1'b1) done_cnt++;
    we_prev = bus.cap_we;
  end

  // One camera byte: data changes with pclk low, rises after two clk periods.
  task automatic pbyte(input logic [7:0] b);
    @(negedge clk);
    bus.cam_pclk = 1'b0;
    bus.cam_data = b;
    @(negedge clk);
    @(negedge clk);
    bus.cam_pclk = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) pbyte(8'h00);
  endtask

  // RGB565 -> RGB444 by keeping the top four bits of each channel.
  function automatic int to444(input int b1, input int b2);
    int r5, g6, b5;
    r5 = b1 >> 3;
    g6 = ((b1 & 7) << 3) | (b2 >> 5);
    b5 = b2 & 31;
    return ((r5 >> 1) << 8) | ((g6 >> 2) << 4) | (b5 >> 1);
  endfunction

  task automatic send_frame(input int nlines, input int short_line, input int short_len,
                            input bit cap, input int rst_line, input int en_line,
                            input bit en_val);
    bit         mcap;
    int         len, cnt, lx;
    logic [7:0] b1, b2;
    mcap = cap;
    cnt  = 0;
    got_addr.delete(); got_pxl.delete(); exp_addr.delete(); exp_pxl.delete();
    done_cnt = 0;
    we_long  = 0;
    idle(4);
    bus.cam_vsync = 1'b0;
    idle(4);
    for (int l = 0; l < nlines; l++) begin
      if (l == en_line) bus.cap_en = en_val;
      if (rst_line >= 0 && l == rst_line + 1) rst = 1'b1;
      len = (l == short_line) ? short_len : InCols;
      lx  = (l < InRows) ? l : InRows - 1;
      bus.cam_href = 1'b1;
      for (int p = 0; p < len; p++) begin
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        if (p == 0 && l == 0) begin b1 = 8'hF8; b2 = 8'h00; end
        else if (p == 8 && l == 8) begin b1 = 8'h07; b2 = 8'hE0; end
        pbyte(b1);
        pbyte(b2);
        if (mcap && (p % 8 == 0) && (lx % 8 == 0) && cnt < ImgPix) begin
          exp_addr.push_back(cnt);
          exp_pxl.push_back(to444(int'(b1), int'(b2)));
          cnt++;
        end
        if (l == rst_line && p == InCols / 2) begin
          rst  = 1'b0;
          mcap = 1'b0;
          #1;
          checks++;
          if (bus.cap_we !== 1'b0) begin
            failures++; $display("FAIL rst_mid_we got=%b exp=0", bus.cap_we);
          end
          checks++;
          if (bus.cap_addr !== '0) begin
            failures++; $display("FAIL rst_mid_addr got=%0d exp=0", bus.cap_addr);
          end
          checks++;
          if (bus.cap_pxl !== '0) begin
            failures++; $display("FAIL rst_mid_pxl got=%h exp=000", bus.cap_pxl);
          end
          checks++;
          if (bus.frame_done !== 1'b0) begin
            failures++; $display("FAIL rst_mid_done got=%b exp=0", bus.frame_done);
          end
        end
      end
      bus.cam_href = 1'b0;
      idle(4);
    end
    bus.cam_vsync = 1'b1;
    idle(3);
  endtask

  task automatic test_reset();
    bus.cap_en = 1'b1; bus.cam_pclk = 1'b0; bus.cam_vsync = 1'b1;
    bus.cam_href = 1'b0; bus.cam_data = 8'h00;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.cap_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", bus.cap_we); end
    checks++;
    if (bus.cap_addr !== '0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", bus.cap_addr); end
    checks++;
    if (bus.cap_pxl !== '0) begin failures++; $display("FAIL reset_pxl got=%h exp=000", bus.cap_pxl); end
    checks++;
    if (bus.frame_done !== 1'b0) begin
      failures++; $display("FAIL reset_done got=%b exp=0", bus.frame_done);
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_full_frame();
    int idx;
    send_frame(InRows, -1, 0, 1'b1, -1, -1, 1'b0);
    checks++;
    if (got_addr.size() != ImgPix) begin
      failures++; $display("FAIL full_count got=%0d exp=%0d", got_addr.size(), ImgPix);
    end
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      checks++;
      if (got_addr[i] != exp_addr[i] || got_pxl[i] != exp_pxl[i]) begin
        failures++;
        $display("FAIL full_write[%0d] got=%0d/%h exp=%0d/%h", i, got_addr[i], got_pxl[i],
                 exp_addr[i], exp_pxl[i]);
      end
    end
    checks++;
    if (got_addr.size() == 0 || got_addr[0] != 0 || got_pxl[0] != 'hF00) begin
      failures++; $display("FAIL full_first got_n=%0d exp=addr0/F00", got_addr.size());
    end
    idx = -1;
    foreach (got_addr[i]) if (got_addr[i] == ImgCols + 1) idx = i;
    checks++;
    if (idx < 0 || got_pxl[idx] != 'h0F0) begin
      failures++; $display("FAIL full_c8l8 got_idx=%0d exp=pxl 0F0 at addr %0d", idx, ImgCols + 1);
    end
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL full_done got=%0d exp=1", done_cnt); end
    checks++;
    if (we_long != 0) begin failures++; $display("FAIL full_we_pulse got=%0d exp=0", we_long); end
  endtask

  task automatic test_short_line();
    send_frame(InRows, 8, 15, 1'b1, -1, -1, 1'b0);
    checks++;
    if (got_addr.size() != 2 * ImgCols + 2) begin
      failures++; $display("FAIL short_count got=%0d exp=%0d", got_addr.size(), 2 * ImgCols + 2);
    end
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      checks++;
      if (got_addr[i] != exp_addr[i] || got_pxl[i] != exp_pxl[i]) begin
        failures++;
        $display("FAIL short_write[%0d] got=%0d/%h exp=%0d/%h", i, got_addr[i], got_pxl[i],
                 exp_addr[i], exp_pxl[i]);
      end
    end
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL short_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_excess_lines();
    send_frame(InRows + 4, -1, 0, 1'b1, -1, -1, 1'b0);
    checks++;
    if (got_addr.size() != ImgPix || got_addr[$] != ImgPix - 1) begin
      failures++; $display("FAIL excess_count got=%0d exp=%0d", got_addr.size(), ImgPix);
    end
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      checks++;
      if (got_addr[i] != exp_addr[i] || got_pxl[i] != exp_pxl[i]) begin
        failures++;
        $display("FAIL excess_write[%0d] got=%0d/%h exp=%0d/%h", i, got_addr[i], got_pxl[i],
                 exp_addr[i], exp_pxl[i]);
      end
    end
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL excess_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    send_frame(InRows, -1, 0, 1'b1, 12, -1, 1'b0);
    checks++;
    if (got_addr.size() != exp_addr.size()) begin
      failures++;
      $display("FAIL rstfr_count got=%0d exp=%0d", got_addr.size(), exp_addr.size());
    end
    checks++;
    if (done_cnt != 0) begin failures++; $display("FAIL rstfr_done got=%0d exp=0", done_cnt); end
    send_frame(InRows, -1, 0, 1'b1, -1, -1, 1'b0);
    checks++;
    if (got_addr.size() != ImgPix || got_addr[0] != 0) begin
      failures++; $display("FAIL post_rst_count got=%0d exp=%0d from addr 0", got_addr.size(), ImgPix);
    end
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      checks++;
      if (got_addr[i] != exp_addr[i] || got_pxl[i] != exp_pxl[i]) begin
        failures++;
        $display("FAIL post_rst_write[%0d] got=%0d/%h exp=%0d/%h", i, got_addr[i], got_pxl[i],
                 exp_addr[i], exp_pxl[i]);
      end
    end
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL post_rst_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_cap_en();
    // Dropping cap_en mid-frame still finishes the current frame.
    send_frame(InRows, -1, 0, 1'b1, -1, 12, 1'b0);
    checks++;
    if (got_addr.size() != ImgPix || done_cnt != 1) begin
      failures++; $display("FAIL en_off_mid got=%0d/%0d exp=%0d/1", got_addr.size(), done_cnt, ImgPix);
    end
    send_frame(InRows, -1, 0, 1'b0, -1, 12, 1'b1);
    checks++;
    if (got_addr.size() != 0) begin
      failures++; $display("FAIL en_off_writes got=%0d exp=0", got_addr.size());
    end
    checks++;
    if (done_cnt != 0) begin failures++; $display("FAIL en_off_done got=%0d exp=0", done_cnt); end
    send_frame(InRows, -1, 0, 1'b1, -1, -1, 1'b0);
    checks++;
    if (got_addr.size() != ImgPix) begin
      failures++; $display("FAIL en_on_next got=%0d exp=%0d", got_addr.size(), ImgPix);
    end
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      checks++;
      if (got_addr[i] != exp_addr[i] || got_pxl[i] != exp_pxl[i]) begin
        failures++;
        $display("FAIL en_on_write[%0d] got=%0d/%h exp=%0d/%h", i, got_addr[i], got_pxl[i],
                 exp_addr[i], exp_pxl[i]);
      end
    end
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL en_on_done got=%0d exp=1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_line();
    test_excess_lines();
    test_reset_mid();
    test_cap_en();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
